// File: rtl/gemm_ctrl_pkg.sv
// gemm_ctrl_pkg: shared FSM state type and timing helper for the GEMM tile controller
package gemm_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, OUT} state_t;
    // The last skewed operand needs M+N cycles to cross the array, plus the PE MAC pipeline.
    function automatic int drain_cycles(input int m, input int n, input int pe_lat);
        return m + n + pe_lat;
    endfunction
endpackage

// File: rtl/operand_skew.sv
// operand_skew: triangular delay line, lane i delayed by i registers, lane 0 combinational
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : advance all delay lines one stage
//   flush      : synchronously zero every stage (takes priority over en)
//   din / dout : LANES packed lanes of DATA_W bits, unmodified apart from the delay
module operand_skew #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic [LANES*DATA_W-1:0] din,
    output logic [LANES*DATA_W-1:0] dout
);
    assign dout[DATA_W-1:0] = din[DATA_W-1:0];
    for (genvar g = 1; g < LANES; g++) begin : g_lane
        logic [DATA_W-1:0] sr_q [g];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int t = 0; t < g; t++) sr_q[t] <= '0;
            end else if (flush) begin
                for (int t = 0; t < g; t++) sr_q[t] <= '0;
            end else if (en) begin
                sr_q[0] <= din[g*DATA_W +: DATA_W];
                for (int t = 1; t < g; t++) sr_q[t] <= sr_q[t-1];
            end
        end
        assign dout[g*DATA_W +: DATA_W] = sr_q[g-1];
    end
endmodule

// File: rtl/gemm_tile_ctrl.sv
// gemm_tile_ctrl: sequencer for one MxN systolic GEMM tile (fetch, skew, drain, row readout)
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_k      : tile command handshake, reduction depth (saturates at K_MAX)
//   op_rd_en/op_rd_k               : operand buffer read strobe and k index
//   op_a_data/op_b_data            : operand vectors, valid one cycle after op_rd_en
//   arr_clear/arr_en               : array accumulator clear and enable
//   arr_a_col/arr_b_row            : skewed operand lanes into the array
//   arr_acc                        : accumulator grid, element (i,j) at index i*N+j
//   res_valid/res_ready/res_row/res_data : one accumulator row per handshake
//   busy/done                      : not idle, one-cycle pulse after the last row is accepted
module gemm_tile_ctrl
    import gemm_ctrl_pkg::*;
#(
    parameter int M      = 16,
    parameter int N      = 16,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 256,
    parameter int PE_LAT = 2,
    localparam int K_W   = $clog2(K_MAX + 1),
    localparam int RD_W  = $clog2(K_MAX),
    localparam int R_W   = $clog2(M)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [K_W-1:0]           cmd_k,
    output logic                     op_rd_en,
    output logic [RD_W-1:0]          op_rd_k,
    input  logic [M*DATA_W-1:0]      op_a_data,
    input  logic [N*DATA_W-1:0]      op_b_data,
    output logic                     arr_clear,
    output logic                     arr_en,
    output logic [M*DATA_W-1:0]      arr_a_col,
    output logic [N*DATA_W-1:0]      arr_b_row,
    input  logic [M*N*ACC_W-1:0]     arr_acc,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [R_W-1:0]           res_row,
    output logic [N*ACC_W-1:0]       res_data,
    output logic                     busy,
    output logic                     done
);
    localparam int DRAIN_N = drain_cycles(M, N, PE_LAT);
    localparam int CNT_MAX = K_MAX > DRAIN_N ? K_MAX : DRAIN_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_len_q, k_len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [R_W-1:0]     row_q, row_d;
    logic               rd_valid_q, done_q;
    logic               stepping, last_row;
    logic [M*DATA_W-1:0] a_in;
    logic [N*DATA_W-1:0] b_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_len_q    <= '0;
            cnt_q      <= '0;
            row_q      <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_len_q    <= k_len_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            rd_valid_q <= op_rd_en;
            done_q     <= last_row;
        end
    end

    always_comb begin
        stepping = state_q == STREAM || state_q == DRAIN;
        last_row = state_q == OUT && res_ready && row_q == R_W'(M - 1);
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid ? CLEAR : IDLE;
            CLEAR:   state_d = k_len_q == '0 ? DRAIN : STREAM;
            STREAM:  state_d = cnt_q == CNT_W'(k_len_q) - CNT_W'(1) ? DRAIN : STREAM;
            DRAIN:   state_d = cnt_q == CNT_W'(DRAIN_N - 1) ? OUT : DRAIN;
            OUT:     state_d = last_row ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
        k_len_d = state_q == IDLE && cmd_valid ? (cmd_k > K_W'(K_MAX) ? K_W'(K_MAX) : cmd_k) : k_len_q;
        // The counter restarts on every state change so it counts cycles within STREAM or DRAIN.
        cnt_d   = stepping && state_d == state_q ? cnt_q + CNT_W'(1) : '0;
        row_d   = state_q == OUT && !last_row ? row_q + R_W'(res_ready) : '0;
    end

    always_comb begin
        cmd_ready = state_q == IDLE;
        busy      = state_q != IDLE;
        arr_clear = state_q == CLEAR;
        arr_en    = stepping;
        op_rd_en  = state_q == STREAM;
        op_rd_k   = op_rd_en ? cnt_q[RD_W-1:0] : '0;
        res_valid = state_q == OUT;
        res_row   = res_valid ? row_q : '0;
        res_data  = res_valid ? arr_acc[int'(row_q) * N * ACC_W +: N * ACC_W] : '0;
        done      = done_q;
    end

    // Buffer data is only meaningful in the cycle after a read; otherwise zeros feed the wavefront.
    assign a_in = rd_valid_q ? op_a_data : '0;
    assign b_in = rd_valid_q ? op_b_data : '0;

    operand_skew #(.LANES(M), .DATA_W(DATA_W)) u_skew_a (
        .clk(clk), .rst_n(rst_n), .en(stepping), .flush(arr_clear), .din(a_in), .dout(arr_a_col)
    );
    operand_skew #(.LANES(N), .DATA_W(DATA_W)) u_skew_b (
        .clk(clk), .rst_n(rst_n), .en(stepping), .flush(arr_clear), .din(b_in), .dout(arr_b_row)
    );
endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// tb_gemm_tile_ctrl: scoreboard bench with operand buffer and systolic array models around the controller
module tb_gemm_tile_ctrl;
    localparam int M = 4, N = 4, DW = 8, AW = 32, KM = 256, PL = 2;
    localparam int KW = $clog2(KM + 1), KIW = $clog2(KM), RW = $clog2(M);

    logic clk = 1'b0, rst_n, cmd_valid, cmd_ready, op_rd_en, arr_clear, arr_en;
    logic res_valid, res_ready, busy, done;
    logic [KW-1:0] cmd_k;
    logic [KIW-1:0] op_rd_k;
    logic [M*DW-1:0] op_a_data, arr_a_col;
    logic [N*DW-1:0] op_b_data, arr_b_row;
    logic [M*N*AW-1:0] arr_acc;
    logic [RW-1:0] res_row;
    logic [N*AW-1:0] res_data;

    gemm_tile_ctrl #(.M(M), .N(N), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM), .PE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .op_rd_en(op_rd_en), .op_rd_k(op_rd_k), .op_a_data(op_a_data), .op_b_data(op_b_data),
        .arr_clear(arr_clear), .arr_en(arr_en), .arr_a_col(arr_a_col), .arr_b_row(arr_b_row),
        .arr_acc(arr_acc), .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_data(res_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Operand buffers, double-banked so a queued command can be prepared while another streams.
    logic signed [DW-1:0] amem [2][KM][M];
    logic signed [DW-1:0] bmem [2][KM][N];
    logic bank_q = 1'b0;
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) bank_q <= ~bank_q;
        for (int i = 0; i < M; i++) op_a_data[i*DW +: DW] <= op_rd_en ? amem[bank_q][op_rd_k][i] : DW'($urandom);
        for (int j = 0; j < N; j++) op_b_data[j*DW +: DW] <= op_rd_en ? bmem[bank_q][op_rd_k][j] : DW'($urandom);
    end

    // Output-stationary systolic array: operands hop one PE per cycle, two-stage MAC.
    logic signed [DW-1:0] ar [M][N], br [M][N];
    logic signed [AW-1:0] pr [M][N], ac [M][N];
    always @(posedge clk) begin
        for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
            if (arr_clear) begin
                ar[i][j] <= '0; br[i][j] <= '0; pr[i][j] <= '0; ac[i][j] <= '0;
            end else if (arr_en) begin
                ar[i][j] <= j == 0 ? $signed(arr_a_col[i*DW +: DW]) : ar[i][j > 0 ? j - 1 : 0];
                br[i][j] <= i == 0 ? $signed(arr_b_row[j*DW +: DW]) : br[i > 0 ? i - 1 : 0][j];
                pr[i][j] <= ar[i][j] * br[i][j];
                ac[i][j] <= ac[i][j] + pr[i][j];
            end
        end
    end
    always_comb begin
        arr_acc = '0;
        for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) arr_acc[(i*N + j)*AW +: AW] = ac[i][j];
    end

    typedef struct { logic [RW-1:0] row; logic [N*AW-1:0] data; } exp_t;
    typedef struct { int t; int lat; int k; } cmd_t;
    exp_t sb_q [$];
    cmd_t cq [$];

    function automatic logic [N*AW-1:0] gold(input int b, input int k, input int i);
        logic [N*AW-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) s = s + amem[b][kk][i] * bmem[b][kk][j];
            r[j*AW +: AW] = AW'(s);
        end
        return r;
    endfunction

    function automatic logic [N*AW-1:0] row_c(input int c);
        logic [N*AW-1:0] r;
        for (int j = 0; j < N; j++) r[j*AW +: AW] = AW'(c);
        return r;
    endfunction

    // Monitor: compares every presented row with the scoreboard head, plus per-command timing.
    bit pend_done = 0, waiting = 0;
    int nrd = 0, nclr = 0, exp_k = 0;
    always @(negedge clk) begin
        bit d_exp;
        exp_t e;
        cmd_t c;
        if (!rst_n) begin
            pend_done = 0;
            waiting = 0;
        end else begin
            d_exp = pend_done;
            pend_done = 0;
            if (done || d_exp) chk("done_pulse", done, d_exp);
            if (cmd_valid && cmd_ready) begin
                nrd = 0; nclr = 0; exp_k = 0; waiting = 1;
            end
            if (arr_clear) nclr++;
            if (op_rd_en) begin
                chk("op_rd_k", op_rd_k, exp_k);
                exp_k++;
                nrd++;
            end
            if (res_valid) begin
                if (waiting) begin
                    waiting = 0;
                    if (cq.size() == 0) chk("unexpected_cmd", 1, 0);
                    else begin
                        c = cq.pop_front();
                        chk("latency", cyc - c.t, c.lat);
                        chk("rd_count", nrd, c.k);
                        chk("clear_count", nclr, 1);
                    end
                end
                if (sb_q.size() == 0) chk("unexpected_row", 1, 0);
                else begin
                    e = sb_q[0];
                    chk("res_row", res_row, e.row);
                    chk("res_data", res_data, e.data);
                    if (res_ready) begin
                        void'(sb_q.pop_front());
                        if (e.row == RW'(M - 1)) pend_done = 1;
                    end
                end
            end
        end
    end

    bit rr = 0;
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 res_ready = rr ? 1'($urandom) : 1'b1;
        end
    end

    int nxt = 1;
    bit use_h = 0;
    int hv [M];

    task automatic fill(input int b, input int mode);
        for (int kk = 0; kk < KM; kk++) begin
            for (int i = 0; i < M; i++)
                amem[b][kk][i] = mode == 0 ? DW'(i + 1) : mode == 1 ? DW'($urandom) : mode == 2 ? -8'sd128 : 8'sd1;
            for (int j = 0; j < N; j++)
                bmem[b][kk][j] = mode == 0 ? 8'sd1 : mode == 1 ? DW'($urandom) : mode == 2 ? -8'sd128 : 8'sd1;
        end
    endtask

    task automatic issue(input int k, input int lat, input bit b2b);
        int ke, b, n;
        ke = k > KM ? KM : k;
        b = nxt;
        cmd_k = KW'(k);
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 3000);
        if (!cmd_ready) begin
            chk("accept_timeout", 1, 0);
            cmd_valid = 1'b0;
            return;
        end
        if (b2b) chk("b2b_accept_in_done", done, 1);
        cq.push_back('{cyc, lat, ke});
        for (int i = 0; i < M; i++) sb_q.push_back('{RW'(i), use_h ? row_c(hv[i]) : gold(b, ke, i)});
        nxt = 1 - nxt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_k = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || cq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || cq.size() != 0) begin
            chk("drain_timeout", 1, 0);
            sb_q.delete();
            cq.delete();
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_op_rd_en"}, {op_rd_en, op_rd_k}, 0);
        chk({tag, "_arr_ctl"}, {arr_clear, arr_en}, 0);
        chk({tag, "_skew_out"}, {arr_a_col, arr_b_row}, 0);
        chk({tag, "_res"}, {res_valid, res_row, done}, 0);
        chk({tag, "_res_data"}, res_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_k = '0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // K=1, A=[1,2,3,4], B=all 1: row i is all i+1.
        fill(nxt, 0);
        use_h = 1;
        for (int i = 0; i < M; i++) hv[i] = i + 1;
        issue(1, 13, 0);
        wait_idle();
        // K=4, random signed operands against the golden product.
        use_h = 0;
        fill(nxt, 1);
        issue(4, 16, 0);
        wait_idle();
        // K=0: no reads, zero grid.
        use_h = 1;
        for (int i = 0; i < M; i++) hv[i] = 0;
        issue(0, 12, 0);
        wait_idle();
        // K=256 at -128 x -128 with a randomly stalling consumer.
        fill(nxt, 2);
        for (int i = 0; i < M; i++) hv[i] = 4194304;
        rr = 1;
        issue(256, 268, 0);
        wait_idle();
        rr = 0;
        // K=300 saturates to 256 reads.
        fill(nxt, 3);
        for (int i = 0; i < M; i++) hv[i] = 256;
        issue(300, 268, 0);
        wait_idle();
        // Back-to-back: the second command is held valid and accepted only in the done cycle.
        use_h = 0;
        fill(nxt, 1);
        fill(1 - nxt, 1);
        issue(2, 14, 0);
        issue(3, 15, 1);
        wait_idle();
        // Reset during STREAM cycle 2 aborts; a later K=1 command is clean.
        fill(nxt, 1);
        issue(4, 16, 0);
        n = 0;
        while (!(op_rd_en && op_rd_k == KIW'(2)) && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("reach_stream2", op_rd_k, 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        sb_q.delete();
        cq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_reset_cmd_ready", cmd_ready, 1);
        fill(nxt, 0);
        use_h = 1;
        for (int i = 0; i < M; i++) hv[i] = i + 1;
        issue(1, 13, 0);
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gemm_tile_ctrl.md
Name: gemm_tile_ctrl

Overview:
Sequencer for one MxN systolic GEMM tile. It accepts a tile command and fetches K operand vectors from the A/B operand buffers. It skews the vectors onto the array's row and column inputs, drives clear and enable, waits for the wavefront to drain, then streams the MxN accumulator grid out one row per handshake.

Parameters:
M, 16, array rows / A lanes
N, 16, array columns / B lanes
DATA_W, 8, signed operand width
ACC_W, 32, accumulator width
K_MAX, 256, maximum reduction depth per command
PE_LAT, 2, PE MAC pipeline depth included in drain
K_W, $clog2(K_MAX+1), derived localparam, command length width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  tile command valid
cmd_ready  out  1  high only in IDLE
cmd_k  in  K_W  reduction depth, 0..K_MAX
op_rd_en  out  1  operand buffer read strobe
op_rd_k  out  $clog2(K_MAX)  k index being read
op_a_data  in  M*DATA_W  A column k, valid exactly 1 cycle after op_rd_en
op_b_data  in  N*DATA_W  B row k, valid exactly 1 cycle after op_rd_en
arr_clear  out  1  array accumulator clear
arr_en  out  1  array enable
arr_a_col  out  M*DATA_W  skewed A lanes
arr_b_row  out  N*DATA_W  skewed B lanes
arr_acc  in  M*N*ACC_W  accumulator grid, row-major, element (i,j) at index i*N+j
res_valid  out  1  result row valid
res_ready  in  1  result row accept
res_row  out  $clog2(M)  row index of res_data
res_data  out  N*ACC_W  arr_acc row res_row
busy  out  1  state != IDLE
done  out  1  1-cycle pulse after last row accepted

Behaviour:
- Reset state: IDLE. All outputs 0 except cmd_ready=1. Skew registers and counters are 0.
- Async reset mid-operation aborts the command. No done is issued.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, OUT.
- IDLE: on cmd_valid&&cmd_ready, latch cmd_k and go to CLEAR. cmd_k>K_MAX saturates to K_MAX.
- CLEAR (1 cycle): arr_clear=1, arr_en=0, skew registers flushed to 0. Next state is STREAM, or DRAIN if k_len==0.
- STREAM (k_len cycles): op_rd_en=1 and op_rd_k=0..k_len-1 incrementing. arr_en=1. Then DRAIN.
- DRAIN (M+N+PE_LAT cycles): arr_en=1, op_rd_en=0. Skew inputs see zeros, so zero products flow in. Then OUT.
- Skew: A lane i is delayed i registers and B lane j is delayed j registers. Lane 0 is a pass-through of the buffer data.
- Skew input is the buffer data when the read issued last cycle was valid, else 0. Skew registers advance every cycle in STREAM/DRAIN.
- OUT: arr_en=0, so the grid is frozen.
  - res_valid=1, res_row=r, res_data=row r of arr_acc (combinational slice).
  - r increments on res_valid&&res_ready.
  - Acceptance of row M-1 gives done=1 for the next cycle and a return to IDLE.
  - res_ready low stalls indefinitely with data held stable.
- Latency: command accepted at cycle T gives the first res_valid at T+2+k_len+M+N+PE_LAT. Example: M=N=4, K=4, PE_LAT=2 gives T+16.
- cmd_valid outside IDLE is ignored; no queueing.
- Back-to-back: a new command may be accepted in the cycle done is high. CLEAR guarantees no carry-over.
- Arithmetic: the controller performs none. Operands pass through the skew unmodified (signed, no extension).

Decomposition:
- Package gemm_ctrl_pkg holds:
  - state_t enum {IDLE, CLEAR, STREAM, DRAIN, OUT};
  - function drain_cycles(M,N,PE_LAT).
- Sub-module operand_skew #(LANES, DATA_W): per-lane triangular delay line with a flush input. Instanced twice, LANES=M for A and LANES=N for B.

Test Plan:
- M=N=4, K=1, A=[1,2,3,4], B=[1,1,1,1] -> row i equals all (i+1). First res_valid at T+13. done pulses once.
- M=N=4, K=4, random signed operands -> each res_data row matches the golden A*B. op_rd_k sequence is 0,1,2,3 on consecutive cycles.
- K=0 command -> no op_rd_en, all four rows zero, res_valid at T+12.
- Extremes: K=256, all A=B=-128 -> every element 4194304. res_ready toggled randomly -> rows in order 0..M-1 with no duplicate or skipped row, and data stable while stalled.
- Two back-to-back commands (second cmd_valid held during the first) -> second accepted only in the done cycle. Its results exclude first-tile contributions. arr_clear is seen exactly once per command.
- rst_n asserted at STREAM cycle 2 -> outputs immediately at reset values, cmd_ready=1 after release. A following K=1 command produces correct results.
